// File: rtl/coinc_window.sv
// coinc_window: per-channel A/B coincidence finder, +/-1 cycle search with fine-time window.
// Latency: the accept/reject pulse for a single sampled at edge n is high in the cycle starting at edge n+3.
// Backpressure: none; fully pipelined, one independent response per enabled single per cycle.
module coinc_window #(
  parameter int NA = 4,
  parameter int NB = 4,
  parameter int TW = 7,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NA-1:0]    singleA,
  input  logic [NA*TW-1:0] tfineA,
  input  logic [NB-1:0]    singleB,
  input  logic [NB*TW-1:0] tfineB,
  input  logic [NA-1:0]    enA,
  input  logic [NB-1:0]    enB,
  input  logic [TW-1:0]    win,
  input  logic             cnt_clr,
  output logic [NA-1:0]    pcoincA,
  output logic [NA-1:0]    ncoincA,
  output logic [NB-1:0]    pcoincB,
  output logic [NB-1:0]    ncoincB,
  output logic [CW-1:0]    pcount
);

  // Differences span one clock period plus one fine-time range, so three
  // extra bits keep the signed value and its magnitude free of overflow.
  localparam int DW = TW + 3;
  localparam logic signed [DW-1:0] PER  = DW'(1) << TW;
  localparam logic signed [DW-1:0] NPER = -PER;

  // Stage 1 holds edge n+1, stage 2 edge n (the single being judged),
  // stage 3 edge n-1; singles are stored raw and masked at compare time.
  logic [NA-1:0]    sa1, sa2, sa3;
  logic [NB-1:0]    sb1, sb2, sb3;
  logic [NA*TW-1:0] ta1, ta2, ta3;
  logic [NB*TW-1:0] tb1, tb2, tb3;

  logic [NA-1:0] match_a, res_pa, res_na;
  logic [NB-1:0] match_b, res_pb, res_nb;

  // |(t_b + bias) - t_a| <= w, where bias carries the whole-cycle offset
  // between the two singles' sampling edges.
  function automatic logic in_win(input logic [TW-1:0] t_a,
                                  input logic [TW-1:0] t_b,
                                  input logic signed [DW-1:0] bias,
                                  input logic [TW-1:0] w);
    logic signed [DW-1:0] d;
    d = $signed({3'b000, t_b}) - $signed({3'b000, t_a}) + bias;
    if (d[DW-1]) d = -d;
    return d <= $signed({3'b000, w});
  endfunction

  // Three-deep history of raw singles and fine times for both sides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa1 <= '0; sa2 <= '0; sa3 <= '0;
      sb1 <= '0; sb2 <= '0; sb3 <= '0;
      ta1 <= '0; ta2 <= '0; ta3 <= '0;
      tb1 <= '0; tb2 <= '0; tb3 <= '0;
    end else begin
      sa1 <= singleA; sa2 <= sa1; sa3 <= sa2;
      sb1 <= singleB; sb2 <= sb1; sb3 <= sb2;
      ta1 <= tfineA;  ta2 <= ta1; ta3 <= ta2;
      tb1 <= tfineB;  tb2 <= tb1; tb3 <= tb2;
    end
  end

  // Compare each stage-2 single against enabled partners at n-1, n and n+1.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int i = 0; i < NA; i++) begin
      for (int j = 0; j < NB; j++) begin
        if (enB[j] && sb3[j] && in_win(ta2[i*TW +: TW], tb3[j*TW +: TW], NPER, win)) match_a[i] = 1'b1;
        if (enB[j] && sb2[j] && in_win(ta2[i*TW +: TW], tb2[j*TW +: TW], '0, win))   match_a[i] = 1'b1;
        if (enB[j] && sb1[j] && in_win(ta2[i*TW +: TW], tb1[j*TW +: TW], PER, win))  match_a[i] = 1'b1;
      end
    end
    for (int j = 0; j < NB; j++) begin
      for (int i = 0; i < NA; i++) begin
        if (enA[i] && sa3[i] && in_win(ta3[i*TW +: TW], tb2[j*TW +: TW], PER, win))  match_b[j] = 1'b1;
        if (enA[i] && sa2[i] && in_win(ta2[i*TW +: TW], tb2[j*TW +: TW], '0, win))   match_b[j] = 1'b1;
        if (enA[i] && sa1[i] && in_win(ta1[i*TW +: TW], tb2[j*TW +: TW], NPER, win)) match_b[j] = 1'b1;
      end
    end
  end

  // Register the verdicts; a disabled channel yields neither pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_pa <= '0; res_na <= '0;
      res_pb <= '0; res_nb <= '0;
    end else begin
      res_pa <= enA & sa2 & match_a;
      res_na <= enA & sa2 & ~match_a;
      res_pb <= enB & sb2 & match_b;
      res_nb <= enB & sb2 & ~match_b;
    end
  end

  // Output pulses, one cycle each.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcoincA <= '0; ncoincA <= '0;
      pcoincB <= '0; ncoincB <= '0;
    end else begin
      pcoincA <= res_pa; ncoincA <= res_na;
      pcoincB <= res_pb; ncoincB <= res_nb;
    end
  end

  // Prompt counter: counts edges that raise any pcoincA bit; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcount <= '0;
    end else if (cnt_clr) begin
      pcount <= '0;
    end else if (|res_pa && pcount != {CW{1'b1}}) begin
      pcount <= pcount + 1'b1;
    end
  end

endmodule
